free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular FIFO of free physical register indices for the out-of-order core.
- Sits between the retirement RAT (producer of freed pregs on commit) and rename (consumer of new pd allocations).
- Maintains a speculative head (rename allocation) and a retired head (advanced at commit).
- On a pipeline flush, the speculative head snaps back to the retired head, so every preg allocated by squashed instructions becomes free again.

Parameters:
- PHYS_REGS, 64, total physical registers.
- ARCH_REGS, 32, architectural registers (pregs 0..ARCH_REGS-1 are held by the RRAT at reset).
- DEPTH, PHYS_REGS-ARCH_REGS, FIFO capacity (power of two).
- PHYS_BITS, $clog2(PHYS_REGS), preg index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk).
- enq_valid  in  1  RRAT frees a preg this cycle; already gated off for rd==x0.
- enq_preg  in  PHYS_BITS  preg being freed.
- deq_req  in  1  rename requests one allocation.
- deq_valid  out  1  a free preg is available this cycle.
- deq_preg  out  PHYS_BITS  preg offered to rename; valid when deq_valid.
- commit_adv  in  1  ROB committed an instruction with rd!=x0 (its allocation is now architectural).
- flush  in  1  mispredict/exception recovery.
- free_count  out  $clog2(DEPTH)+1  entries between spec head and tail.

Behaviour:
- Storage: mem[DEPTH] of PHYS_BITS.
- Pointers: tail, head_spec, head_ret. Each has $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Pointer arithmetic is modulo 2*DEPTH.
- Reset (rst==0):
  - mem[i] = ARCH_REGS+i.
  - tail = DEPTH with wrap bit set, i.e. index 0 with MSB 1 (full).
  - head_spec = head_ret = 0.
  - free_count = DEPTH, deq_valid = 1, deq_preg = ARCH_REGS.
- Empty condition: head_spec == tail.
- Full condition: index bits equal and wrap bits differ.
- Outputs, combinational from state:
  - deq_valid = !empty && !flush.
  - deq_preg = mem[head_spec index].
  - free_count = tail - head_spec.
- Dequeue: if deq_req && deq_valid, head_spec increments at posedge. deq_req while !deq_valid is ignored; no state change.
- Enqueue: if enq_valid, mem[tail] = enq_preg and tail increments. No bypass to same-cycle dequeue; the entry is visible next cycle.
- Simultaneous enqueue + dequeue: both pointers move; free_count is unchanged.
- commit_adv: head_ret increments. Invariant: head_ret never passes head_spec.
- Flush:
  - head_spec = head_ret + (commit_adv ? 1 : 0).
  - Dequeue is suppressed that cycle.
  - Enqueue and commit_adv in the same cycle are still honoured.
  - tail is unaffected.
  - Latency: restored allocations are visible on deq_preg the cycle after flush.
- Enqueue when full is illegal; it cannot occur with correct ROB/RRAT behaviour. Simulation-only assertion fires; the write is dropped and pointers hold.
- commit_adv when head_ret == head_spec is illegal (assertion).
- Reset mid-operation overrides every other input; all state returns to reset values in one cycle.

Optional Feature:
- Macro: FREE_LIST_BYPASS_EN.
- Defined:
  - When empty && enq_valid && !flush, deq_valid = 1 and deq_preg = enq_preg in the same cycle.
  - If deq_req is also high, the write still occurs, and tail and head_spec both increment, so head_ret ordering is preserved.
  - free_count stays 0.
- Undefined: behaviour exactly as in Behaviour; deq_valid low while empty regardless of enq_valid.

Test Plan:
- Reset then 32 back-to-back deq_req -> deq_preg sequence 32,33,...,63; deq_valid drops after the 32nd; free_count = 0.
- From empty, enq_valid with enq_preg=5, deq_req same cycle:
  - bypass off -> deq_valid=0 that cycle; next cycle deq_preg=5.
  - bypass on -> deq_valid=1 and deq_preg=5 same cycle; free_count stays 0.
- After reset, dequeue 10 (pregs 32..41), commit_adv x4, then flush -> next cycle deq_preg=36, free_count=28.
- Flush with commit_adv and enq_valid (preg 7) same cycle, after 10 dequeues and 4 prior commits -> head_spec = head_ret+1 (deq_preg=37); 7 is appended at tail; free_count = 28.
- Wrap-around: 200 cycles of random balanced enq/deq with free_count kept within 1..DEPTH-1 -> the deq_preg stream equals a scoreboard FIFO model, and no preg is ever duplicated.
- rst driven low mid-burst (free_count=3, head_ret lagging) -> next cycle free_count=32, deq_preg=32, and all pointers match reset values.

Source files
------------

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register indices.
//
// The RRAT pushes freed pregs at the tail. Rename pops new pd allocations at
// the speculative head. The retired head advances on every commit of an
// instruction that writes a register. A flush snaps the speculative head back
// to the retired head, which returns every squashed allocation to the pool.
//
// Optional feature macro: FREE_LIST_BYPASS_EN. When it is defined and the list
// is empty, a preg enqueued this cycle is offered to rename in the same cycle.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-low
//   enq_valid   RRAT frees a preg this cycle
//   enq_preg    preg being freed
//   deq_req     rename requests one allocation
//   deq_valid   a free preg is available this cycle
//   deq_preg    preg offered to rename (meaningful when deq_valid)
//   commit_adv  ROB committed an instruction with rd != x0
//   flush       mispredict / exception recovery
//   free_count  entries between speculative head and tail
module free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
  parameter int PHYS_BITS = $clog2(PHYS_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [PHYS_BITS-1:0]     enq_preg,
  input  logic                     deq_req,
  output logic                     deq_valid,
  output logic [PHYS_BITS-1:0]     deq_preg,
  input  logic                     commit_adv,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PHYS_BITS-1:0] mem_q [DEPTH];
  logic [PHYS_BITS-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [PTR_W-1:0]     head_spec_q, head_spec_d;
  logic [PTR_W-1:0]     head_ret_q, head_ret_d;

  logic empty;
  logic full;
  logic do_enq;
  logic do_deq;

  always_comb begin
    empty = (head_spec_q == tail_q);
    full  = (tail_q[IDX_W-1:0] == head_spec_q[IDX_W-1:0]) &&
            (tail_q[IDX_W] != head_spec_q[IDX_W]);

`ifdef FREE_LIST_BYPASS_EN
    // Empty list forwards the preg being freed straight to rename.
    deq_valid = (!empty || enq_valid) && !flush;
    deq_preg  = empty ? enq_preg : mem_q[head_spec_q[IDX_W-1:0]];
`else
    deq_valid = !empty && !flush;
    deq_preg  = mem_q[head_spec_q[IDX_W-1:0]];
`endif

    free_count = tail_q - head_spec_q;

    // An enqueue into a full list is dropped so the pointers stay coherent.
    do_enq = enq_valid && !full;
    do_deq = deq_req && deq_valid;

    mem_d = mem_q;
    if (do_enq) begin
      mem_d[tail_q[IDX_W-1:0]] = enq_preg;
    end

    tail_d     = do_enq ? tail_q + PTR_W'(1) : tail_q;
    head_ret_d = head_ret_q + PTR_W'(commit_adv);

    // Flush restores to the retired head including this cycle's commit.
    if (flush) begin
      head_spec_d = head_ret_d;
    end else if (do_deq) begin
      head_spec_d = head_spec_q + PTR_W'(1);
    end else begin
      head_spec_d = head_spec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PHYS_BITS'(ARCH_REGS + i);
      end
      // Index 0 with the wrap bit set: every non-architectural preg is free.
      tail_q      <= {1'b1, {IDX_W{1'b0}}};
      head_spec_q <= '0;
      head_ret_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      tail_q      <= tail_d;
      head_spec_q <= head_spec_d;
      head_ret_q  <= head_ret_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (!(enq_valid && full))
        else $error("free_list: enqueue while full");
      assert (!(commit_adv && (head_ret_q == head_spec_q)))
        else $error("free_list: commit with no outstanding allocation");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
  localparam int PB        = $clog2(PHYS_REGS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enq_valid = 1'b0;
  logic [PB-1:0] enq_preg = '0;
  logic          deq_req = 1'b0;
  logic          deq_valid;
  logic [PB-1:0] deq_preg;
  logic          commit_adv = 1'b0;
  logic          flush = 1'b0;
  logic [$clog2(DEPTH):0] free_count;

  free_list #(.PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_preg(enq_preg),
    .deq_req(deq_req), .deq_valid(deq_valid), .deq_preg(deq_preg),
    .commit_adv(commit_adv), .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Reference model: q holds every entry from the retired head to the tail,
  // spec_off is how many of them rename has taken speculatively.
  int q[$];
  int spec_off;
  int held[$];   // pregs outside the list, available to be freed again
  int tests = 0;
  int fails = 0;
  logic [31:0] obs_v, obs_p, obs_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(ARCH_REGS + i);
    spec_off = 0;
    held.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; deq_req = 0; enq_valid = 0; commit_adv = 0; flush = 0; enq_preg = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input bit req, input bit enq, input int preg, input bit cmt, input bit fl);
    bit ev, emp, fire;
    int ep, efc;
    @(negedge clk);
    deq_req = req; enq_valid = enq; enq_preg = PB'(preg); commit_adv = cmt; flush = fl;
    #2;
    emp = (spec_off == q.size());
    ev  = !emp && !fl;
    ep  = emp ? 0 : q[spec_off];
`ifdef FREE_LIST_BYPASS_EN
    if (emp && enq && !fl) begin ev = 1; ep = preg; end
`endif
    efc = q.size() - spec_off;
    obs_v = 32'(deq_valid); obs_p = 32'(deq_preg); obs_fc = 32'(free_count);
    chk("deq_valid", obs_v, 32'(ev));
    chk("free_count", obs_fc, 32'(efc));
    if (ev) chk("deq_preg", obs_p, 32'(ep));
    fire = req && ev;
    @(posedge clk);
    if (fire && !emp) spec_off++;
    if (enq) q.push_back(preg);
    if (fire && emp) spec_off++;
    if (cmt) begin held.push_back(q.pop_front()); spec_off--; end
    if (fl) spec_off = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and a full drain.
    reset_dut();
    step(0, 0, 0, 0, 0);
    chk("rst_valid", obs_v, 1);
    chk("rst_count", obs_fc, 32);
    chk("rst_preg", obs_p, 32);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0, 0);
      chk("drain_seq", obs_p, 32'(ARCH_REGS + i));
    end
    step(0, 0, 0, 0, 0);
    chk("empty_valid", obs_v, 0);
    chk("empty_count", obs_fc, 0);

    // Enqueue into an empty list with a same-cycle request.
    step(1, 1, 5, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
    chk("bypass_valid", obs_v, 1);
    chk("bypass_preg", obs_p, 5);
    step(0, 0, 0, 0, 0);
    chk("bypass_count", obs_fc, 0);
`else
    chk("nobypass_valid", obs_v, 0);
    step(1, 0, 0, 0, 0);
    chk("nobypass_next_preg", obs_p, 5);
    chk("nobypass_next_valid", obs_v, 1);
`endif

    // Flush after 10 allocations and 4 commits.
    reset_dut();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    chk("flush_suppress", obs_v, 0);
    step(0, 0, 0, 0, 0);
    chk("flush_preg", obs_p, 36);
    chk("flush_count", obs_fc, 28);

    // Flush with a same-cycle commit and enqueue.
    reset_dut();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 7, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("flushc_preg", obs_p, 37);
    chk("flushc_count", obs_fc, 28);

    // Random balanced traffic with wrap-around.
    reset_dut();
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 200; i++) begin
      int fc, preg;
      bit req, enq, cmt, fl, found;
      fc   = q.size() - spec_off;
      req  = ($urandom_range(0, 1) == 1) && (fc > 1);
      enq  = ($urandom_range(0, 1) == 1) && (held.size() > 0) && (q.size() < DEPTH);
      cmt  = ($urandom_range(0, 1) == 1) && (spec_off > 0);
      fl   = ($urandom_range(0, 31) == 0);
      preg = enq ? held.pop_front() : 0;
      step(req, enq, preg, cmt, fl);
      if (obs_v[0]) begin
        found = 0;
        foreach (held[k]) if (held[k] == int'(obs_p)) found = 1;
        chk("no_dup", 32'(found), 0);
      end
    end

    // Reset in the middle of a burst.
    reset_dut();
    for (int i = 0; i < 29; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("burst_count", obs_fc, 3);
    reset_dut();
    step(0, 0, 0, 0, 0);
    chk("midrst_count", obs_fc, 32);
    chk("midrst_preg", obs_p, 32);
    chk("midrst_valid", obs_v, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("midrst_ret_preg", obs_p, 32);
    chk("midrst_ret_count", obs_fc, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
